ins_mem_loader: RTL

Instruction-memory loader for the single-cycle MIPS core, acting as the write-side counterpart to the core's instruction fetch. It accepts a byte stream over a valid/ready handshake, assembles big-endian 32-bit words, and writes them sequentially into the instruction memory write port. It holds the core in reset until the programmed image is complete, so the first fetch after release sees a fully loaded program.

---
 rtl/ins_mem_loader.sv | 120 ++++++++++++
 1 files changed

// File: rtl/ins_mem_loader.sv
// Instruction-memory loader: assembles a big-endian byte stream into 32-bit words,
// writes them sequentially into the instruction memory and holds the core in reset
// until the whole image has been written.
module ins_mem_loader #(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned AddrWidth = 8
) (
  input  logic                 clk,
  input  logic                 RST,
  input  logic                 Start,
  input  logic [AddrWidth:0]   Num_Words,
  input  logic                 Byte_Valid,
  input  logic [7:0]           Byte_Data,
  output logic                 Byte_Ready,
  output logic                 WR_Enable,
  output logic [AddrWidth-1:0] WR_Addr,
  output logic [DataWidth-1:0] WR_Data,
  output logic                 Core_RST,
  output logic                 Busy,
  output logic                 Done,
  output logic [7:0]           Checksum
);

  typedef enum logic [1:0] {StIdle, StRecv, StWrite, StDone} state_e;

  // Largest loadable image: one word per address, so the address never wraps onto 0.
  localparam logic [AddrWidth:0]   MaxWords = {1'b1, {AddrWidth{1'b0}}};
  localparam logic [AddrWidth:0]   CntOne   = 1;
  localparam logic [AddrWidth-1:0] AddrOne  = 1;

  state_e                 state_q, state_d;
  logic [AddrWidth:0]     num_q, num_d;
  logic [AddrWidth:0]     cnt_q, cnt_d;
  logic [AddrWidth-1:0]   addr_q, addr_d;
  logic [DataWidth-1:0]   data_q, data_d;
  logic [1:0]             idx_q, idx_d;
  logic [7:0]             csum_q, csum_d;

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (RST) begin
      state_q <= StIdle;
      num_q   <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      idx_q   <= '0;
      csum_q  <= '0;
    end else begin
      state_q <= state_d;
      num_q   <= num_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
      csum_q  <= csum_d;
    end
  end

  // Next-state logic: latch a load on Start, gather four bytes, write, repeat.
  always_comb begin
    state_d = state_q;
    num_d   = num_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    idx_d   = idx_q;
    csum_d  = csum_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (Start) begin
          num_d   = (Num_Words > MaxWords) ? MaxWords : Num_Words;
          cnt_d   = '0;
          addr_d  = '0;
          idx_d   = '0;
          csum_d  = '0;
          state_d = (num_d == '0) ? StDone : StRecv;
        end
      end
      StRecv: begin
        // Byte_Ready is high throughout this state, so Byte_Valid alone accepts.
        if (Byte_Valid) begin
          unique case (idx_q)
            2'd0: data_d[31:24] = Byte_Data;
            2'd1: data_d[23:16] = Byte_Data;
            2'd2: data_d[15:8]  = Byte_Data;
            2'd3: data_d[7:0]   = Byte_Data;
            default: ;
          endcase
          csum_d = csum_q + Byte_Data;
          idx_d  = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            state_d = StWrite;
          end
        end
      end
      StWrite: begin
        cnt_d = cnt_q + CntOne;
        if (cnt_d == num_q) begin
          state_d = StDone;
        end else begin
          addr_d  = addr_q + AddrOne;
          state_d = StRecv;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs decode only registered state, so nothing flows straight from inputs.
  assign Byte_Ready = (state_q == StRecv);
  assign WR_Enable  = (state_q == StWrite);
  assign WR_Addr    = addr_q;
  assign WR_Data    = data_q;
  assign Core_RST   = (state_q != StDone);
  assign Busy       = (state_q == StRecv) || (state_q == StWrite);
  assign Done       = (state_q == StDone);
  assign Checksum   = csum_q;

endmodule
